final_system: RTL and testbench

FINAL_SYSTEM -- requirements
Module: final_system

---
 rtl/final_system_if.sv | 24 ++
 rtl/final_system.sv | 276 +++++++++++++++++++++++++++
 tb/tb_final_system.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/final_system_if.sv
// Serial-side signal bundle of final_system: command line in, response line
// out, and the two receive error flags.
interface final_system_if;
    logic rx;
    logic tx;
    logic parity_error;
    logic framing_error;

    // Host side: drives the command line and watches the response and flags.
    modport master (
        output rx,
        input  tx,
        input  parity_error,
        input  framing_error
    );

    // Device side: receives commands and drives the response and flags.
    modport slave (
        input  rx,
        output tx,
        output parity_error,
        output framing_error
    );
endinterface

// File: rtl/final_system.sv
// UART command processor: receives 8E1 frames, decodes write/read/ALU
// commands against a 16x8 register file and returns read/ALU results as
// 8E1 frames on the transmit line.
module final_system #(
    parameter int CLKS_PER_BIT = 80
) (
    input  logic REF_CLK,
    input  logic RST_N,
    input  logic UART_RX_IN,
    output logic UART_TX_O,
    output logic parity_error,
    output logic framing_error
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
    } rx_state_e;

    rx_state_e       rx_state_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;
    logic            rx_par_q;
    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    logic            rx_valid_q;
    logic            rx_bad_q;
    logic [7:0]      rx_data_q;
    logic            perr_q, ferr_q;
    logic            rx_par_bad;

    // Odd number of ones over data+parity means the even-parity check failed.
    assign rx_par_bad = ^{rx_shift_q, rx_par_q};

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= UART_RX_IN;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // Receiver FSM: mid-bit sampling, error flags held until the next
    // accepted start bit, one-clock valid or bad pulse per completed frame.
    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_bad_q   <= 1'b0;
            rx_data_q  <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_bad_q   <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_END) begin
                        rx_cnt_q <= '0;
                        if (rx_s2_q) begin
                            // Line back high at mid-start: glitch, not a frame.
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_DATA;
                            rx_bit_q   <= '0;
                            perr_q     <= 1'b0;
                            ferr_q     <= 1'b0;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_PAR;
                        else                  rx_bit_q   <= rx_bit_q + 1'b1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_PAR: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q   <= '0;
                        rx_par_q   <= rx_s2_q;
                        rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_END) begin
                        // Back to idle at the stop sample so a following
                        // start edge is caught immediately.
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                        if (!rx_s2_q) ferr_q <= 1'b1;
                        if (rx_par_bad) perr_q <= 1'b1;
                        if (!rx_s2_q || rx_par_bad) begin
                            rx_bad_q <= 1'b1;
                        end else begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_shift_q;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic            tx_q;
    logic            tx_busy_q;
    logic [9:0]      tx_shift_q;
    logic [3:0]      tx_left_q;
    logic [CW-1:0]   tx_cnt_q;
    logic            tx_start_q;
    logic [7:0]      tx_data_q;

    // Transmitter: start bit goes out the clock after tx_start_q, then
    // data LSB first, even parity, stop; line rests high between frames.
    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_left_q  <= '0;
            tx_cnt_q   <= '0;
        end else if (!tx_busy_q) begin
            if (tx_start_q) begin
                tx_q       <= 1'b0;
                tx_busy_q  <= 1'b1;
                tx_shift_q <= {1'b1, ^tx_data_q, tx_data_q};
                tx_left_q  <= 4'd10;
                tx_cnt_q   <= '0;
            end
        end else if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            if (tx_left_q == 4'd0) begin
                tx_busy_q <= 1'b0;
            end else begin
                tx_q       <= tx_shift_q[0];
                tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                tx_left_q  <= tx_left_q - 1'b1;
            end
        end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Command FSM, register file and ALU
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC, SEND
    } cmd_state_e;

    cmd_state_e      cmd_state_q;
    logic [3:0]      addr_q;
    logic [7:0]      regs_q [16];

    function automatic logic [7:0] alu_f(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [3:0] f);
        logic [7:0] r;
        case (f)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = a * b;
            4'h3: r = (b == 8'd0) ? 8'd0 : a / b;
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = ~(a & b);
            4'h7: r = ~(a | b);
            4'h8: r = a ^ b;
            4'h9: r = ~(a ^ b);
            4'hA: r = {7'd0, a == b};
            4'hB: r = {7'd0, a > b};
            4'hC: r = {7'd0, a < b};
            4'hD: r = {1'b0, a[7:1]};
            4'hE: r = {a[6:0], 1'b0};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Command decoder: any bad frame aborts back to IDLE without writing;
    // bytes arriving in SEND are dropped.
    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            cmd_state_q <= IDLE;
            addr_q      <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
        end else begin
            tx_start_q <= 1'b0;
            if (rx_bad_q) begin
                cmd_state_q <= IDLE;
            end else begin
                case (cmd_state_q)
                    IDLE: if (rx_valid_q) begin
                        case (rx_data_q)
                            8'hAA:   cmd_state_q <= WR_ADDR;
                            8'hBB:   cmd_state_q <= RD_ADDR;
                            8'hCC:   cmd_state_q <= ALU_A;
                            8'hDD:   cmd_state_q <= ALU_FUNC;
                            default: cmd_state_q <= IDLE;
                        endcase
                    end
                    WR_ADDR: if (rx_valid_q) begin
                        addr_q      <= rx_data_q[3:0];
                        cmd_state_q <= WR_DATA;
                    end
                    WR_DATA: if (rx_valid_q) begin
                        regs_q[addr_q] <= rx_data_q;
                        cmd_state_q    <= IDLE;
                    end
                    RD_ADDR: if (rx_valid_q) begin
                        tx_data_q   <= regs_q[rx_data_q[3:0]];
                        cmd_state_q <= SEND;
                    end
                    ALU_A: if (rx_valid_q) begin
                        regs_q[0]   <= rx_data_q;
                        cmd_state_q <= ALU_B;
                    end
                    ALU_B: if (rx_valid_q) begin
                        regs_q[1]   <= rx_data_q;
                        cmd_state_q <= ALU_FUNC;
                    end
                    ALU_FUNC: if (rx_valid_q) begin
                        tx_data_q   <= alu_f(regs_q[0], regs_q[1], rx_data_q[3:0]);
                        cmd_state_q <= SEND;
                    end
                    SEND: if (!tx_busy_q) begin
                        tx_start_q  <= 1'b1;
                        cmd_state_q <= IDLE;
                    end
                    default: cmd_state_q <= IDLE;
                endcase
            end
        end
    end

    assign UART_TX_O     = tx_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;

endmodule

// File: tb/tb_final_system.sv
// Directed bench for final_system: commands go out as serial frames, the
// expected response bytes are queued, and a monitor decodes UART_TX_O and
// checks each frame against the queue.
module tb_final_system;
    localparam int CPB = 16;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_mid = 0;
    logic [7:0] exp_q [$];

    final_system_if u_if ();

    final_system #(.CLKS_PER_BIT(CPB)) dut (
        .REF_CLK       (clk),
        .RST_N         (rst_n),
        .UART_RX_IN    (u_if.rx),
        .UART_TX_O     (u_if.tx),
        .parity_error  (u_if.parity_error),
        .framing_error (u_if.framing_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // One 8E1 frame; bad_par flips the parity bit, stop sets the stop level.
    task automatic send_frame(input logic [7:0] d, input bit bad_par = 1'b0,
                              input bit stop = 1'b1);
        logic [10:0] bits;
        bits = {stop, (^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            u_if.rx = bits[i];
            if (i == 10) begin
                repeat (CPB/2) @(negedge clk);
                last_mid = cyc;
                repeat (CPB - CPB/2) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        u_if.rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 40*CPB) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (CPB) @(negedge clk);
    endtask

    task automatic cmd2(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
        exp_q.push_back(e);
        send_frame(a);
        send_frame(b);
        drain();
    endtask

    // Response monitor / scoreboard
    initial begin
        logic [10:0] fr;
        logic [7:0]  e;
        bit          aborted;
        forever begin
            @(negedge u_if.tx);
            if (rst_n) begin
                tests++;
                if (cyc - last_mid > 12) begin
                    fails++;
                    $display("FAIL tx_latency: %0d cycles after stop mid, expected <= 12",
                             cyc - last_mid);
                end
                aborted = 1'b0;
                repeat (CPB/2) @(negedge clk);
                for (int i = 0; i < 11; i++) begin
                    if (!rst_n) aborted = 1'b1;
                    fr[i] = u_if.tx;
                    if (i < 10) repeat (CPB) @(negedge clk);
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_tx: got frame data %h, expected no frame", fr[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_start", {7'd0, fr[0]}, 8'h00);
                        check("tx_data", fr[8:1], e);
                        check("tx_parity", {7'd0, fr[9]}, {7'd0, ^e});
                        check("tx_stop", {7'd0, fr[10]}, 8'h01);
                    end
                end
            end
        end
    end

    localparam logic [7:0] FN_EXP [16] = '{
        8'hFF, 8'hE1, 8'h10, 8'h10, 8'h00, 8'hFF, 8'hFF, 8'h00,
        8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h78, 8'hE0, 8'h00
    };

    initial begin
        logic [7:0] fe;
        int t;
        u_if.rx = 1'b1;
        rst_n   = 1'b0;
        #23;
        check("rst_tx", {7'd0, u_if.tx}, 8'h01);
        check("rst_perr", {7'd0, u_if.parity_error}, 8'h00);
        check("rst_ferr", {7'd0, u_if.framing_error}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("idle_tx", {7'd0, u_if.tx}, 8'h01);
        check("idle_flags", {6'd0, u_if.parity_error, u_if.framing_error}, 8'h00);

        // Write reg0 = 0x05 then read it back
        send_frame(8'hAA);
        send_frame(8'hA0);
        send_frame(8'h05);
        cmd2(8'hBB, 8'hA0, 8'h05);

        // Reset in the middle of a received frame
        u_if.rx = 1'b0;
        repeat (4*CPB) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("midrx_rst_tx", {7'd0, u_if.tx}, 8'h01);
        u_if.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2*CPB) @(negedge clk);
        cmd2(8'hBB, 8'hA0, 8'h00);
        cmd2(8'hBB, 8'h03, 8'h00);

        // ALU
        exp_q.push_back(8'h06);
        send_frame(8'hCC); send_frame(8'h03); send_frame(8'h03); send_frame(8'h00);
        drain();
        cmd2(8'hDD, 8'h01, 8'h00);
        exp_q.push_back(8'hFE);
        send_frame(8'hCC); send_frame(8'h03); send_frame(8'h05); send_frame(8'h01);
        drain();
        cmd2(8'hBB, 8'h00, 8'h03);
        cmd2(8'hBB, 8'h01, 8'h05);
        cmd2(8'hDD, 8'hF2, 8'h0F);
        exp_q.push_back(8'h10);
        send_frame(8'hCC); send_frame(8'hF0); send_frame(8'h0F); send_frame(8'h02);
        drain();
        for (int f = 0; f < 16; f++) begin
            fe = FN_EXP[f];
            cmd2(8'hDD, 8'(f), fe);
        end
        exp_q.push_back(8'h00);
        send_frame(8'hCC); send_frame(8'h07); send_frame(8'h00); send_frame(8'h03);
        drain();
        exp_q.push_back(8'h01);
        send_frame(8'hCC); send_frame(8'h02); send_frame(8'h09); send_frame(8'h0C);
        drain();

        // Parity error: flag set, FSM stays idle, cleared by next good frame
        send_frame(8'hAA, 1'b1);
        check("perr_set", {7'd0, u_if.parity_error}, 8'h01);
        check("perr_ferr", {7'd0, u_if.framing_error}, 8'h00);
        cmd2(8'hBB, 8'h00, 8'h02);
        check("perr_clear", {7'd0, u_if.parity_error}, 8'h00);
        // Parity error aborts a write in progress
        send_frame(8'hAA);
        send_frame(8'h05);
        send_frame(8'h07, 1'b1);
        check("perr_abort", {7'd0, u_if.parity_error}, 8'h01);
        cmd2(8'hBB, 8'h05, 8'h00);

        // Framing error aborts, glitch ignored
        send_frame(8'hAA);
        send_frame(8'h02, 1'b0, 1'b0);
        check("ferr_set", {7'd0, u_if.framing_error}, 8'h01);
        send_frame(8'h09);
        check("ferr_clear", {7'd0, u_if.framing_error}, 8'h00);
        send_frame(8'h44, 1'b0, 1'b0);
        u_if.rx = 1'b0;
        repeat (CPB/4) @(negedge clk);
        u_if.rx = 1'b1;
        repeat (2*CPB) @(negedge clk);
        check("glitch_ferr", {7'd0, u_if.framing_error}, 8'h01);
        check("glitch_perr", {7'd0, u_if.parity_error}, 8'h00);
        cmd2(8'hBB, 8'h02, 8'h00);
        check("ferr_clear2", {7'd0, u_if.framing_error}, 8'h00);

        // Reset in the middle of a transmitted frame
        send_frame(8'hBB);
        send_frame(8'h00);
        t = 0;
        while (u_if.tx && t < 40*CPB) begin
            @(negedge clk);
            t++;
        end
        check("tx_seen", {7'd0, u_if.tx}, 8'h00);
        repeat (3*CPB) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("midtx_rst_tx", {7'd0, u_if.tx}, 8'h01);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30*CPB) @(negedge clk);
        check("post_rst_tx", {7'd0, u_if.tx}, 8'h01);
        cmd2(8'hBB, 8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
